// File: rtl/inst_prefetch_pkg.sv
// Shared widths, reset word, queue depth default and FSM encodings for the
// instruction prefetcher.
package inst_prefetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;
    localparam int DEPTH_DEFAULT = 4;
    localparam logic [INST_ADDR_W-1:0] ADDR_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } pf_state_t;

endpackage

// File: rtl/inst_prefetch_fifo.sv
// Address+data queue for prefetched words: push at tail, pop at head,
// synchronous clear, occupancy count.
module prefetch_fifo
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      clear,
    input  logic [INST_ADDR_W-1:0]    push_addr,
    input  logic [INST_W-1:0]         push_data,
    output logic [INST_ADDR_W-1:0]    head_addr,
    output logic [INST_W-1:0]         head_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [INST_ADDR_W-1:0] addr_mem [DEPTH];
    logic [INST_W-1:0]      data_mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    // Guards keep the queue from overflowing or underflowing even if a
    // caller misbehaves; pointers wrap naturally since DEPTH is a power of two.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher between pc_reg and a one-outstanding-request memory.
// Optional same-cycle forwarding of read data is enabled by PREFETCH_BYPASS_EN.
//
// state   | meaning
// IDLE    | no request outstanding
// FETCH   | request outstanding, its data will be kept
// DISCARD | request outstanding, its data will be dropped
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic                   ce_i,
    input  logic                   hold_i,
    output logic [INST_W-1:0]      inst_o,
    output logic                   inst_valid_o,
    output logic                   stall_o,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [INST_W-1:0]      mem_rdata_i
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    pf_state_t              state, state_nxt;
    logic                   run;
    logic [INST_ADDR_W-1:0] fa, fa_nxt, fa_eff, expect_addr;
    logic [INST_ADDR_W-1:0] head_addr, mem_addr_nxt;
    logic [INST_W-1:0]      head_data;
    logic [CW-1:0]          fifo_count, count_nxt;
    logic                   hit, miss, pop, push, clear, issue;
    logic                   fetch_ack, bypass, mem_req_nxt;

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_addr (mem_addr_o),
        .push_data (mem_rdata_i),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (fifo_count)
    );

    always_comb begin
        expect_addr = fa;
        if (fifo_count != '0)       expect_addr = head_addr;
        else if (state == ST_FETCH) expect_addr = mem_addr_o;

        hit       = ce_i && (fifo_count != '0) && (head_addr == pc_i);
        miss      = ce_i && !hold_i && (pc_i != expect_addr);
        clear     = !ce_i || miss;
        fetch_ack = (state == ST_FETCH) && mem_ack_i && ce_i && !miss;
`ifdef PREFETCH_BYPASS_EN
        bypass    = fetch_ack && (fifo_count == '0) && (mem_addr_o == pc_i);
`else
        bypass    = 1'b0;
`endif
        pop       = hit && !hold_i;
        push      = fetch_ack && !(bypass && !hold_i);

        count_nxt = fifo_count;
        if (clear)             count_nxt = '0;
        else if (push && !pop) count_nxt = fifo_count + CW'(1);
        else if (pop && !push) count_nxt = fifo_count - CW'(1);

        // A request completing this cycle frees the single outstanding slot,
        // so the next one can go out back-to-back.
        fa_eff = miss ? pc_i : fa;
        issue  = ce_i && run && ((state == ST_IDLE) || mem_ack_i) && (count_nxt < FULL);
        fa_nxt = issue ? fa_eff + ADDR_STEP : fa_eff;

        mem_req_nxt  = mem_req_o;
        mem_addr_nxt = mem_addr_o;
        if (issue) begin
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = fa_eff;
        end else if (mem_ack_i && (state != ST_IDLE)) begin
            mem_req_nxt  = 1'b0;
        end

        state_nxt = state;
        case (state)
            ST_IDLE:    if (issue) state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack_i)          state_nxt = issue ? ST_FETCH : ST_IDLE;
                else if (clear)         state_nxt = ST_DISCARD;
            end
            ST_DISCARD: if (mem_ack_i) state_nxt = issue ? ST_FETCH : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase

        inst_valid_o = hit || bypass;
        inst_o       = ZERO_WORD;
        if (hit)         inst_o = head_data;
        else if (bypass) inst_o = mem_rdata_i;
        stall_o      = ce_i && !inst_valid_o;
    end

    // run delays the first issue to the second edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            run        <= 1'b0;
            fa         <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            state      <= state_nxt;
            run        <= 1'b1;
            fa         <= fa_nxt;
            mem_req_o  <= mem_req_nxt;
            mem_addr_o <= mem_addr_nxt;
        end
    end

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, which sets the number of prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (rst==0 resets).
REQ-004 SHALL have port pc_i, input, 32 bits (`InstAddrBus): fetch address from pc_reg.
REQ-005 SHALL have port ce_i, input, 1 bit: fetch enable from pc_reg.
REQ-006 SHALL have port hold_i, input, 1 bit: core pipeline stalled; the head entry is not consumed.
REQ-007 SHALL have port inst_o, output, 32 bits (`InstBus): instruction to the if_id stage.
REQ-008 SHALL have port inst_valid_o, output, 1 bit: inst_o is the word at pc_i this cycle.
REQ-009 SHALL have port stall_o, output, 1 bit: equals ce_i && !inst_valid_o; pc_reg holds its PC while stall_o is 1.
REQ-010 SHALL have ports mem_req_o (output, 1 bit) and mem_addr_o (output, 32 bits): registered memory read request and word address.
REQ-011 SHALL have ports mem_ack_i (input, 1 bit) and mem_rdata_i (input, 32 bits): one-cycle acknowledge, with read data valid in the same cycle.

Function
REQ-012 SHALL hold mem_req_o high with mem_addr_o stable from issue until mem_ack_i is seen; mem_ack_i may arrive in the first request cycle or any later cycle; at most one request SHALL be outstanding.
REQ-013 SHALL implement the FSM states IDLE (no request outstanding), FETCH (request outstanding, result kept) and DISCARD (request outstanding, result dropped).
REQ-014 SHALL issue the next request at fetch address fa when ce_i==1 and count+outstanding<DEPTH; after an issue, fa SHALL become fa+4 modulo 2^32, so 0xFFFFFFFC is followed by 0x00000000.
REQ-015 SHALL define a hit as ce_i && count>0 && head_addr==pc_i; on a hit, inst_o SHALL equal the head data and inst_valid_o SHALL be 1 in the same cycle (combinational).
REQ-016 SHALL pop the head on a hit with hold_i==0; a pop and a push in the same cycle SHALL leave count unchanged.
REQ-017 SHALL treat the situation ce_i && hold_i==0 && pc_i != expected address as a miss, where the expected address is head_addr if count>0, else the address of the outstanding request, else fa. A miss SHALL:
- clear the queue;
- set fa to pc_i;
- move FETCH to DISCARD.
REQ-018 SHALL, in the state DISCARD, drop mem_rdata_i when mem_ack_i arrives and go to IDLE.
REQ-019 SHALL, when ce_i==0, clear the queue and not issue requests; an outstanding request SHALL complete as in the state DISCARD.
REQ-020 SHALL, with count==DEPTH (queue full), issue no request; it SHALL never overflow or underflow.
REQ-021 SHALL drive inst_o to 0 whenever inst_valid_o==0.

Reset
REQ-022 SHALL, while rst==0, asynchronously force:
- mem_req_o=0, mem_addr_o=0, inst_o=0, inst_valid_o=0;
- count=0, fa=0x00000000, FSM state IDLE.
REQ-023 SHALL drop any acknowledge belonging to a request cut off by reset; after reset release, the first request SHALL be issued no earlier than the second rising edge.

Configuration
REQ-024 SHALL, with PREFETCH_BYPASS_EN defined, forward mem_rdata_i to inst_o with inst_valid_o=1 in the mem_ack_i cycle when count==0, the state is FETCH, and the request address equals pc_i; the entry SHALL also be popped at once if hold_i==0, else pushed.
REQ-025 SHALL, without PREFETCH_BYPASS_EN, always push acknowledged data into the queue, so the data becomes visible one cycle later.

Structure
REQ-026 SHALL take `InstAddrBus, `InstBus, `ZeroWord, the FSM state encodings and the DEPTH default from the shared defines.v.
REQ-027 SHALL contain one sub-module, prefetch_fifo (address+data queue with push/pop/clear and count); the FSM and the request logic SHALL live in inst_prefetch.

Verification
REQ-028 SHALL be checked with a bench using a zero-wait memory (ack in the request cycle, rdata=addr^0xA5A5A5A5):
- pc 0x0,0x4,0x8,... → the first inst_valid_o arrives 2 cycles (bypass) or 3 cycles (no bypass) after reset release, then one word per cycle with stall_o=0.
REQ-029 SHALL be checked with a jump and a slow memory:
- the memory acks 3 cycles after the request; pc jumps 0x8→0x100 while the request to 0x10 is outstanding;
- the 0x10 data is dropped, the next mem_addr_o is 0x100, and inst_o=0x100^0xA5A5A5A5 when valid.
REQ-030 SHALL be checked with the queue filled and the core held: hold_i=1 for 10 cycles with ce_i=1 → count reaches DEPTH, mem_req_o stays 0, and the same inst_o is presented throughout.
REQ-031 SHALL be checked across address wrap: start pc=0xFFFFFFF8 → requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order.
REQ-032 SHALL be checked with reset mid-operation: rst=0 asynchronously during an outstanding request → mem_req_o=0 and inst_valid_o=0 immediately, with no stale push after release.
REQ-033 SHALL be checked with a simultaneous push and pop at count==DEPTH-1 → count is unchanged and data order is preserved.
